// File: rtl/maxpool2x2_stream.sv
// 2x2 stride-2 pooling stage (max or floor-average) on a raster, channel-interleaved
// activation stream with ready/valid flow control and frame/row markers.
module maxpool2x2_stream #(
    parameter int DATA_W    = 8,
    parameter int IMG_W     = 8,
    parameter int IMG_H     = 8,
    parameter int CH        = 1,
    parameter int POOL_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_sof,
    output logic                     out_eol,
    output logic                     frame_done
);

    localparam int ACC_W    = DATA_W + 1;
    localparam int SUM_W    = DATA_W + 2;
    localparam int CH_W     = (CH > 1) ? $clog2(CH) : 1;
    localparam int COL_W    = $clog2(IMG_W);
    localparam int ROW_W    = $clog2(IMG_H);
    localparam int OUT_W    = IMG_W / 2;
    localparam int COL_USED = OUT_W * 2;
    localparam int ROW_USED = (IMG_H / 2) * 2;
    localparam int LB_D     = OUT_W * CH;
    localparam int LB_AW    = (LB_D > 1) ? $clog2(LB_D) : 1;

    localparam logic [CH_W-1:0]  CH_LAST       = CH_W'(CH - 1);
    localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_USED_LAST = COL_W'(COL_USED - 1);
    localparam logic [ROW_W-1:0] ROW_USED_LAST = ROW_W'(ROW_USED - 1);

    // Horizontal combine: max keeps the sign-extended winner, average keeps the full sum.
    function automatic logic signed [ACC_W-1:0] pair_op(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [ACC_W-1:0] ax;
        logic signed [ACC_W-1:0] bx;
        ax = a;
        bx = b;
        if (POOL_MODE == 0) pair_op = (ax > bx) ? ax : bx;
        else                pair_op = ax + bx;
    endfunction

    // Floor division of a four-sample sum; the result always fits DATA_W.
    function automatic logic signed [DATA_W-1:0] avg_round(
        input logic signed [SUM_W-1:0] sum
    );
        logic signed [SUM_W-1:0] shifted;
        shifted   = sum >>> 2;
        avg_round = DATA_W'(shifted);
    endfunction

    // Vertical combine of the buffered even-row pair with the odd-row pair.
    function automatic logic signed [DATA_W-1:0] final_op(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        logic signed [SUM_W-1:0] ax;
        logic signed [SUM_W-1:0] bx;
        logic signed [SUM_W-1:0] mx;
        ax = a;
        bx = b;
        mx = (ax > bx) ? ax : bx;
        if (POOL_MODE == 0) final_op = DATA_W'(mx);
        else                final_op = avg_round(ax + bx);
    endfunction

    logic [CH_W-1:0]  ch_cnt;
    logic [COL_W-1:0] col_cnt;
    logic [ROW_W-1:0] row_cnt;

    logic signed [DATA_W-1:0] hold [CH];
    logic signed [ACC_W-1:0]  lbuf [LB_D];

    logic                     accept_p0;
    logic                     col_used_p0;
    logic                     row_used_p0;
    logic                     hold_we_p0;
    logic                     lb_we_p0;
    logic                     load_p0;
    logic                     last_p0;
    logic                     sof_p0;
    logic                     eol_p0;
    logic [LB_AW-1:0]         lb_idx_p0;
    logic signed [DATA_W-1:0] hold_rd_p0;
    logic signed [ACC_W-1:0]  lb_rd_p0;
    logic signed [ACC_W-1:0]  pair_p0;
    logic signed [DATA_W-1:0] result_p0;

    always_comb begin
        in_ready  = !out_valid || out_ready;
        accept_p0 = in_valid && in_ready;
    end

    // Stage p0: decode the accepted sample position and form the pooled value.
    always_comb begin
        col_used_p0 = (col_cnt <= COL_USED_LAST);
        row_used_p0 = (row_cnt <= ROW_USED_LAST);
        hold_we_p0  = accept_p0 && col_used_p0 && row_used_p0 && !col_cnt[0];
        lb_we_p0    = accept_p0 && col_used_p0 && row_used_p0 && col_cnt[0] && !row_cnt[0];
        load_p0     = accept_p0 && col_used_p0 && row_used_p0 && col_cnt[0] && row_cnt[0];
        last_p0     = (ch_cnt == CH_LAST) && (col_cnt == COL_LAST) && (row_cnt == ROW_LAST);
        sof_p0      = (row_cnt == ROW_W'(1)) && (col_cnt == COL_W'(1)) && (ch_cnt == '0);
        eol_p0      = (col_cnt == COL_USED_LAST) && (ch_cnt == CH_LAST);
        lb_idx_p0   = LB_AW'(int'(col_cnt >> 1) * CH + int'(ch_cnt));
        hold_rd_p0  = hold[ch_cnt];
        lb_rd_p0    = lbuf[lb_idx_p0];
        pair_p0     = pair_op(hold_rd_p0, in_data);
        result_p0   = final_op(lb_rd_p0, pair_p0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_cnt  <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (accept_p0) begin
            if (ch_cnt == CH_LAST) begin
                ch_cnt <= '0;
                if (col_cnt == COL_LAST) begin
                    col_cnt <= '0;
                    row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + ROW_W'(1);
                end else begin
                    col_cnt <= col_cnt + COL_W'(1);
                end
            end else begin
                ch_cnt <= ch_cnt + CH_W'(1);
            end
        end
    end

    // Storage is never read before it is written within a frame, so it carries no reset.
    always_ff @(posedge clk) begin
        if (hold_we_p0) hold[ch_cnt]     <= in_data;
        if (lb_we_p0)   lbuf[lb_idx_p0]  <= pair_p0;
    end

    // Stage p1: output register, loaded and drained in the same cycle when both occur.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sof    <= 1'b0;
            out_eol    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept_p0 && last_p0;
            if (load_p0) begin
                out_valid <= 1'b1;
                out_data  <= result_p0;
                out_sof   <= sof_p0;
                out_eol   <= eol_p0;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_sof   <= 1'b0;
                out_eol   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Bench for maxpool2x2_stream: four configurations (max 4x4, avg 4x4, max 4x2x2ch, max 5x5)
// driven with directed and random frames, checked against an array-based pooling model.
module tb_maxpool2x2_stream;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              in_valid   [N];
    logic              in_ready   [N];
    logic signed [7:0] in_data    [N];
    logic              out_valid  [N];
    logic              out_ready  [N];
    logic signed [7:0] out_data   [N];
    logic              out_sof    [N];
    logic              out_eol    [N];
    logic              frame_done [N];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int inst;
        int d;
        bit s;
        bit e;
    } obs_t;
    obs_t obs_q[$];
    int   fd_cnt [N];

    maxpool2x2_stream #(.DATA_W(8), .IMG_W(4), .IMG_H(4), .CH(1), .POOL_MODE(0)) u_max (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .out_sof(out_sof[0]), .out_eol(out_eol[0]),
        .frame_done(frame_done[0]));

    maxpool2x2_stream #(.DATA_W(8), .IMG_W(4), .IMG_H(4), .CH(1), .POOL_MODE(1)) u_avg (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .out_sof(out_sof[1]), .out_eol(out_eol[1]),
        .frame_done(frame_done[1]));

    maxpool2x2_stream #(.DATA_W(8), .IMG_W(4), .IMG_H(2), .CH(2), .POOL_MODE(0)) u_ch2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_data(out_data[2]), .out_sof(out_sof[2]), .out_eol(out_eol[2]),
        .frame_done(frame_done[2]));

    maxpool2x2_stream #(.DATA_W(8), .IMG_W(5), .IMG_H(5), .CH(1), .POOL_MODE(0)) u_odd (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .in_data(in_data[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
        .out_data(out_data[3]), .out_sof(out_sof[3]), .out_eol(out_eol[3]),
        .frame_done(frame_done[3]));

    // Output monitor: record every handshake and count frame_done pulses.
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (rst_n && out_valid[k] && out_ready[k])
                obs_q.push_back('{k, int'(out_data[k]), out_sof[k], out_eol[k]});
            if (frame_done[k]) fd_cnt[k]++;
        end
    end

    // Reference: pooled output list of one frame in emission order.
    function automatic void model(input int w, input int h, input int ch, input int mode,
                                  input int v[$], output int ed[$], output bit es[$],
                                  output bit ee[$]);
        for (int oy = 0; oy < h / 2; oy++)
            for (int ox = 0; ox < w / 2; ox++)
                for (int c = 0; c < ch; c++) begin
                    int a, b, p, q, r;
                    a = v[((2 * oy) * w + 2 * ox) * ch + c];
                    b = v[((2 * oy) * w + 2 * ox + 1) * ch + c];
                    p = v[((2 * oy + 1) * w + 2 * ox) * ch + c];
                    q = v[((2 * oy + 1) * w + 2 * ox + 1) * ch + c];
                    if (mode == 0) begin
                        r = a;
                        if (b > r) r = b;
                        if (p > r) r = p;
                        if (q > r) r = q;
                    end else begin
                        r = (a + b + p + q) >>> 2;
                    end
                    ed.push_back(r);
                    es.push_back(oy == 0 && ox == 0 && c == 0);
                    ee.push_back(ox == w / 2 - 1 && c == ch - 1);
                end
    endfunction

    task automatic rand_frame(input int n, output int v[$]);
        for (int i = 0; i < n; i++) v.push_back(int'($urandom_range(0, 255)) - 128);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present samples in order; returns #1 after the edge that accepted the last one.
    task automatic drive(input int k, input int vals[$], input int n);
        for (int i = 0; i < n; i++) begin
            int waited;
            waited      = 0;
            in_valid[k] = 1'b1;
            in_data[k]  = 8'(vals[i]);
            @(negedge clk);
            while (!in_ready[k] && waited < 200) begin
                @(negedge clk);
                waited++;
            end
            if (!in_ready[k]) begin
                n_checks++;
                n_fail++;
                $display("FAIL drive_timeout inst=%0d sample=%0d in_ready=0 required 1", k, i);
                in_valid[k] = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        in_valid[k] = 1'b0;
    endtask

    task automatic collect(input int k, output int d[$], output bit s[$], output bit e[$]);
        foreach (obs_q[i])
            if (obs_q[i].inst == k) begin
                d.push_back(obs_q[i].d);
                s.push_back(obs_q[i].s);
                e.push_back(obs_q[i].e);
            end
    endtask

    int basic[$] = '{1, 2, 3, 4, 5, 6, 7, 8, -1, -2, -3, -4, -5, -6, -7, -8};

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            n_checks++;
            if ({out_valid[k], out_sof[k], out_eol[k], frame_done[k], in_ready[k], out_data[k]}
                !== 13'b0000_1_0000_0000) begin
                n_fail++;
                $display("FAIL reset_state inst=%0d got v/sof/eol/fd/rdy/data=%b required 0000100000000",
                         k, {out_valid[k], out_sof[k], out_eol[k], frame_done[k], in_ready[k],
                             out_data[k]});
            end
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_max_basic();
        int ed[$] = '{6, 8, -1, -3};
        bit es[$] = '{1, 0, 0, 0};
        bit ee[$] = '{0, 1, 0, 1};
        int gd[$];
        bit gs[$], ge[$];
        obs_q.delete();
        fd_cnt[0] = 0;
        drive(0, basic, 16);
        n_checks++;
        if (frame_done[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL max_frame_done_edge got %b required 1", frame_done[0]);
        end
        idle(4);
        n_checks++;
        if (fd_cnt[0] != 1) begin
            n_fail++;
            $display("FAIL max_frame_done_count got %0d required 1", fd_cnt[0]);
        end
        collect(0, gd, gs, ge);
        n_checks++;
        if (gd.size() != ed.size()) begin
            n_fail++;
            $display("FAIL max_basic_count got %0d required %0d", gd.size(), ed.size());
        end
        for (int i = 0; i < ed.size() && i < gd.size(); i++) begin
            n_checks++;
            if (gd[i] !== ed[i] || gs[i] !== es[i] || ge[i] !== ee[i]) begin
                n_fail++;
                $display("FAIL max_basic[%0d] got d=%0d sof=%0b eol=%0b required d=%0d sof=%0b eol=%0b",
                         i, gd[i], gs[i], ge[i], ed[i], es[i], ee[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int ed[$] = '{6, 8, -1, -3};
        int gd[$];
        bit gs[$], ge[$];
        obs_q.delete();
        fd_cnt[0]    = 0;
        out_ready[0] = 1'b0;
        fork
            drive(0, basic, 16);
            begin
                int waited;
                waited = 0;
                @(negedge clk);
                while (!out_valid[0] && waited < 100) begin
                    @(negedge clk);
                    waited++;
                end
                for (int c = 0; c < 5; c++) begin
                    n_checks++;
                    if ({out_valid[0], in_ready[0], out_data[0]} !== {1'b1, 1'b0, 8'sd6}) begin
                        n_fail++;
                        $display("FAIL bp_hold[%0d] got valid=%b ready=%b data=%0d required valid=1 ready=0 data=6",
                                 c, out_valid[0], in_ready[0], out_data[0]);
                    end
                    @(negedge clk);
                end
                @(posedge clk);
                #1 out_ready[0] = 1'b1;
            end
        join
        idle(4);
        collect(0, gd, gs, ge);
        n_checks++;
        if (gd.size() != ed.size() || fd_cnt[0] != 1) begin
            n_fail++;
            $display("FAIL bp_count got outputs=%0d frames=%0d required outputs=4 frames=1",
                     gd.size(), fd_cnt[0]);
        end
        for (int i = 0; i < ed.size() && i < gd.size(); i++) begin
            n_checks++;
            if (gd[i] !== ed[i]) begin
                n_fail++;
                $display("FAIL bp_data[%0d] got %0d required %0d", i, gd[i], ed[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int ed[$] = '{6, 8, -1, -3};
        bit es[$] = '{1, 0, 0, 0};
        int gd[$];
        bit gs[$], ge[$];
        drive(0, basic, 6);
        n_checks++;
        if ({out_valid[0], out_data[0]} !== {1'b1, 8'sd6}) begin
            n_fail++;
            $display("FAIL latency got valid=%b data=%0d required valid=1 data=6",
                     out_valid[0], out_data[0]);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({out_valid[0], out_sof[0], out_eol[0], frame_done[0], out_data[0]} !== 12'h000) begin
            n_fail++;
            $display("FAIL mid_reset_outputs got %b required 000000000000",
                     {out_valid[0], out_sof[0], out_eol[0], frame_done[0], out_data[0]});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        obs_q.delete();
        fd_cnt[0] = 0;
        drive(0, basic, 16);
        idle(4);
        collect(0, gd, gs, ge);
        n_checks++;
        if (gd.size() != ed.size() || fd_cnt[0] != 1) begin
            n_fail++;
            $display("FAIL post_reset_count got outputs=%0d frames=%0d required outputs=4 frames=1",
                     gd.size(), fd_cnt[0]);
        end
        for (int i = 0; i < ed.size() && i < gd.size(); i++) begin
            n_checks++;
            if (gd[i] !== ed[i] || gs[i] !== es[i]) begin
                n_fail++;
                $display("FAIL post_reset[%0d] got d=%0d sof=%0b required d=%0d sof=%0b",
                         i, gd[i], gs[i], ed[i], es[i]);
            end
        end
    endtask

    task automatic test_avg();
        for (int p = 0; p < 3; p++) begin
            int v[$];
            int ed[$];
            bit ee[$] = '{0, 1, 0, 1};
            int gd[$];
            bit gs[$], ge[$];
            if (p == 0) begin
                v  = basic;
                ed = '{3, 5, -4, -6};
            end else begin
                for (int i = 0; i < 16; i++) v.push_back(p == 1 ? -128 : 127);
                for (int i = 0; i < 4; i++) ed.push_back(p == 1 ? -128 : 127);
            end
            obs_q.delete();
            drive(1, v, 16);
            idle(4);
            collect(1, gd, gs, ge);
            n_checks++;
            if (gd.size() != ed.size()) begin
                n_fail++;
                $display("FAIL avg_count[p%0d] got %0d required %0d", p, gd.size(), ed.size());
            end
            for (int i = 0; i < ed.size() && i < gd.size(); i++) begin
                n_checks++;
                if (gd[i] !== ed[i] || ge[i] !== ee[i]) begin
                    n_fail++;
                    $display("FAIL avg[p%0d][%0d] got d=%0d eol=%0b required d=%0d eol=%0b",
                             p, i, gd[i], ge[i], ed[i], ee[i]);
                end
            end
        end
    endtask

    task automatic test_multichannel();
        int v[$];
        int ed[$] = '{6, 60, 8, 80};
        bit es[$] = '{1, 0, 0, 0};
        bit ee[$] = '{0, 0, 0, 1};
        int gd[$];
        bit gs[$], ge[$];
        for (int i = 1; i <= 8; i++) begin
            v.push_back(i);
            v.push_back(10 * i);
        end
        obs_q.delete();
        drive(2, v, 16);
        idle(4);
        collect(2, gd, gs, ge);
        n_checks++;
        if (gd.size() != ed.size()) begin
            n_fail++;
            $display("FAIL ch2_count got %0d required %0d", gd.size(), ed.size());
        end
        for (int i = 0; i < ed.size() && i < gd.size(); i++) begin
            n_checks++;
            if (gd[i] !== ed[i] || gs[i] !== es[i] || ge[i] !== ee[i]) begin
                n_fail++;
                $display("FAIL ch2[%0d] got d=%0d sof=%0b eol=%0b required d=%0d sof=%0b eol=%0b",
                         i, gd[i], gs[i], ge[i], ed[i], es[i], ee[i]);
            end
        end
    endtask

    task automatic test_odd_dims();
        int v[$];
        int ed[$] = '{6, 8, 16, 18};
        bit es[$] = '{1, 0, 0, 0};
        bit ee[$] = '{0, 1, 0, 1};
        int gd[$];
        bit gs[$], ge[$];
        for (int i = 0; i < 25; i++) v.push_back(i);
        obs_q.delete();
        fd_cnt[3] = 0;
        drive(3, v, 25);
        n_checks++;
        if (frame_done[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL odd_frame_done_edge got %b required 1", frame_done[3]);
        end
        idle(4);
        collect(3, gd, gs, ge);
        n_checks++;
        if (gd.size() != ed.size() || fd_cnt[3] != 1) begin
            n_fail++;
            $display("FAIL odd_count got outputs=%0d frames=%0d required outputs=4 frames=1",
                     gd.size(), fd_cnt[3]);
        end
        for (int i = 0; i < ed.size() && i < gd.size(); i++) begin
            n_checks++;
            if (gd[i] !== ed[i] || gs[i] !== es[i] || ge[i] !== ee[i]) begin
                n_fail++;
                $display("FAIL odd[%0d] got d=%0d sof=%0b eol=%0b required d=%0d sof=%0b eol=%0b",
                         i, gd[i], gs[i], ge[i], ed[i], es[i], ee[i]);
            end
        end
    endtask

    // Random frames against the model, optionally with random downstream stalls.
    task automatic test_random_frames(input int k, input int w, input int h, input int ch,
                                      input int mode, input int nf, input bit bp,
                                      input string name);
        for (int f = 0; f < nf; f++) begin
            int v[$];
            int ed[$];
            bit es[$], ee[$];
            int gd[$];
            bit gs[$], ge[$];
            bit done;
            rand_frame(w * h * ch, v);
            model(w, h, ch, mode, v, ed, es, ee);
            obs_q.delete();
            fd_cnt[k] = 0;
            done      = 1'b0;
            fork
                begin
                    drive(k, v, v.size());
                    done = 1'b1;
                end
                begin
                    while (bp && !done) begin
                        @(posedge clk);
                        #1;
                        if (!done) out_ready[k] = 1'($urandom_range(0, 1));
                    end
                end
            join
            out_ready[k] = 1'b1;
            idle(4);
            collect(k, gd, gs, ge);
            n_checks++;
            if (gd.size() != ed.size() || fd_cnt[k] != 1) begin
                n_fail++;
                $display("FAIL %s_count[f%0d] got outputs=%0d frames=%0d required outputs=%0d frames=1",
                         name, f, gd.size(), fd_cnt[k], ed.size());
            end
            for (int i = 0; i < ed.size() && i < gd.size(); i++) begin
                n_checks++;
                if (gd[i] !== ed[i] || gs[i] !== es[i] || ge[i] !== ee[i]) begin
                    n_fail++;
                    $display("FAIL %s[f%0d][%0d] got d=%0d sof=%0b eol=%0b required d=%0d sof=%0b eol=%0b",
                             name, f, i, gd[i], gs[i], ge[i], ed[i], es[i], ee[i]);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < N; k++) begin
            in_valid[k]  = 1'b0;
            in_data[k]   = '0;
            out_ready[k] = 1'b1;
            fd_cnt[k]    = 0;
        end
        test_reset();
        test_max_basic();
        test_backpressure();
        test_reset_mid_frame();
        test_avg();
        test_multichannel();
        test_odd_dims();
        test_random_frames(3, 5, 5, 1, 0, 1, 1'b0, "odd_next");
        test_random_frames(0, 4, 4, 1, 0, 3, 1'b0, "max_rand");
        test_random_frames(1, 4, 4, 1, 1, 3, 1'b0, "avg_rand");
        test_random_frames(2, 4, 2, 2, 0, 3, 1'b1, "ch2_rand_bp");
        test_random_frames(0, 4, 4, 1, 0, 2, 1'b1, "max_rand_bp");
        test_random_frames(1, 4, 4, 1, 1, 2, 1'b1, "avg_rand_bp");
        test_random_frames(3, 5, 5, 1, 0, 2, 1'b1, "odd_rand_bp");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
